// File: rtl/fetch_queue_unit_if.sv
// Bundle for the fetch queue: instruction-memory request/response, redirect
// and the decode-side output channel.
interface fetch_queue_unit_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  // Output channel: a transfer happens on a cycle where out_valid && out_ready;
  // out_valid never depends on out_ready and the head is held while it waits.
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [WIDTH-1:0] out_pc;
  logic [CW-1:0]    count;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front-end: one outstanding memory read at a time feeding a
// small in-order queue toward decode, flushed by branch redirects.
module fetch_queue_unit #(
  parameter int               WIDTH    = 64,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  fetch_queue_unit_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic             outstanding_q, outstanding_d;
  logic             discard_q, discard_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic [31:0]      instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];

  logic rsp, issue, push, pop;

  // Reserving a slot for the in-flight read keeps pushes from ever overflowing.
  assign rsp   = bus.imem_rvalid & outstanding_q;
  assign issue = reset & ~bus.redirect_valid & (~outstanding_q | bus.imem_rvalid) &
                 (({1'b0, count_q} + (CW + 1)'(outstanding_q)) < DEPTH_W);
  assign push  = rsp & ~discard_q & ~bus.redirect_valid;
  assign pop   = (count_q != '0) & bus.out_ready & ~bus.redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pend_pc_d     = pend_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (bus.redirect_valid) begin
      fetch_pc_d    = bus.redirect_pc;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      // A read still in flight must be swallowed when it eventually returns.
      outstanding_d = outstanding_q & ~bus.imem_rvalid;
      discard_d     = outstanding_q & ~bus.imem_rvalid;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (rsp) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end
      if (issue) begin
        outstanding_d = 1'b1;
        pend_pc_d     = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      pend_pc_q     <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pend_pc_q     <= pend_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= bus.imem_rdata;
      pc_mem[tail_q]    <= pend_pc_q;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = instr_mem[head_q];
  assign bus.out_pc    = pc_mem[head_q];
  assign bus.count     = count_q;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios with literal expectations,
// then randomized traffic checked cycle by cycle against a queue-level model.
module tb_fetch_queue_unit;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_queue_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fetch_queue_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  // ---------------- reference model ----------------
  logic [WIDTH+31:0] exp_q[$];     // {pc, instr}, head at index 0
  logic [WIDTH-1:0]  m_pc, m_pend;
  logic              m_out, m_disc;
  logic              exp_req;

  // ---------------- memory environment ----------------
  logic              mem_busy, mem_resp, stray_en;
  logic [WIDTH-1:0]  mem_addr;
  int                mem_cnt, mem_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc   = '0;
    m_pend = '0;
    m_out  = 1'b0;
    m_disc = 1'b0;
  endtask

  task automatic drive(input logic rdy, input logic redir, input logic [WIDTH-1:0] rpc);
    mem_resp            = mem_busy && (mem_cnt == 0);
    bus.imem_rvalid     = mem_resp || (!mem_busy && stray_en && ($urandom_range(0, 9) == 0));
    bus.imem_rdata      = mem_resp ? mem_addr[31:0] : $urandom;
    bus.redirect_valid  = redir;
    bus.redirect_pc     = rpc;
    bus.out_ready       = rdy;
  endtask

  task automatic compare_all();
    exp_req = rst_n && !bus.redirect_valid && (!m_out || bus.imem_rvalid) &&
              ((exp_q.size() + int'(m_out)) < DEPTH);
    chk("imem_req", 64'(bus.imem_req), 64'(exp_req));
    if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    chk("count", 64'(bus.count), 64'(exp_q.size()));
    if (exp_q.size() != 0) begin
      chk("out_pc", bus.out_pc, exp_q[0][WIDTH+31:32]);
      chk("out_instr", 64'(bus.out_instr), 64'(exp_q[0][31:0]));
    end
  endtask

  task automatic mem_update();
    int lat;
    if (mem_resp) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (exp_req) begin
      lat      = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
      mem_busy = 1'b1;
      mem_addr = m_pc;
      mem_cnt  = lat - 1;
    end
  endtask

  task automatic model_update();
    logic rv;
    rv = bus.imem_rvalid;
    if (!rst_n) begin
      model_reset();
    end else if (bus.redirect_valid) begin
      exp_q.delete();
      m_pc = bus.redirect_pc;
      if (rv) begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end else begin
        m_disc = m_out;
      end
    end else begin
      if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
      if (rv && m_out) begin
        if (!m_disc) exp_q.push_back({m_pend, bus.imem_rdata});
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
      if (exp_req) begin
        m_out  = 1'b1;
        m_pend = m_pc;
        m_pc   = m_pc + 64'd4;
      end
    end
  endtask

  // One clock: drive at negedge, compare, advance model, return just past posedge.
  task automatic cycle(input logic rdy, input logic redir, input logic [WIDTH-1:0] rpc);
    @(negedge clk);
    drive(rdy, redir, rpc);
    #1;
    compare_all();
    mem_update();
    model_update();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges, checks the immediate effect, holds it, releases.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
    chk("rst_imem_addr", bus.imem_addr, 64'd0);
    model_reset();
    repeat (4) cycle(1'b0, 1'b0, '0);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic             rdy, redir;
    logic [WIDTH-1:0] rpc;
    rst_n              = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    mem_busy = 1'b0; mem_resp = 1'b0; mem_cnt = 0; mem_addr = '0;
    mem_lat  = 1; stray_en = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Streaming with decode always ready
    cycle(1'b1, 1'b0, '0);
    chk("s1_out_valid_c1", 64'(bus.out_valid), 64'd0);
    chk("s1_addr_c1", bus.imem_addr, 64'h4);
    cycle(1'b1, 1'b0, '0);
    chk("s1_out_valid_c2", 64'(bus.out_valid), 64'd1);
    chk("s1_pc0", bus.out_pc, 64'h0);
    chk("s1_instr0", 64'(bus.out_instr), 64'h0);
    cycle(1'b1, 1'b0, '0);
    chk("s1_pc1", bus.out_pc, 64'h4);
    cycle(1'b1, 1'b0, '0);
    chk("s1_pc2", bus.out_pc, 64'h8);
    chk("s1_count", 64'(bus.count), 64'd1);

    // Fill while decode stalls, then drain
    do_reset();
    repeat (6) cycle(1'b0, 1'b0, '0);
    chk("s2_full_count", 64'(bus.count), 64'd4);
    chk("s2_full_head", bus.out_pc, 64'h0);
    chk("s2_full_addr", bus.imem_addr, 64'h10);
    cycle(1'b1, 1'b0, '0);
    chk("s2_pop0", bus.out_pc, 64'h4);
    chk("s2_count3", 64'(bus.count), 64'd3);
    cycle(1'b1, 1'b0, '0);
    chk("s2_pop1", bus.out_pc, 64'h8);
    cycle(1'b1, 1'b0, '0);
    chk("s2_pop2", bus.out_pc, 64'hC);
    cycle(1'b1, 1'b0, '0);
    chk("s2_resume", bus.out_pc, 64'h10);

    // Redirect while 0x8 is in flight: its late response is dropped
    do_reset();
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    mem_lat = 2;
    cycle(1'b1, 1'b0, '0);
    mem_lat = 1;
    cycle(1'b1, 1'b1, 64'h100);
    chk("s3_count", 64'(bus.count), 64'd0);
    chk("s3_out_valid", 64'(bus.out_valid), 64'd0);
    chk("s3_addr", bus.imem_addr, 64'h100);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("s3_pc100", bus.out_pc, 64'h100);
    cycle(1'b1, 1'b0, '0);
    chk("s3_pc104", bus.out_pc, 64'h104);

    // Redirect, response and pop all in one cycle
    do_reset();
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 64'h200);
    chk("s4_count", 64'(bus.count), 64'd0);
    chk("s4_addr", bus.imem_addr, 64'h200);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("s4_pc200", bus.out_pc, 64'h200);

    // Address wrap at the top of the space
    do_reset();
    cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("s5_pc_top", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("s5_instr_top", 64'(bus.out_instr), 64'hFFFF_FFFC);
    cycle(1'b1, 1'b0, '0);
    chk("s5_pc_wrap", bus.out_pc, 64'h0);

    // Reset mid-stream with a read in flight
    do_reset();
    cycle(1'b1, 1'b0, '0);
    chk("s6_restart_addr", bus.imem_addr, 64'h4);
    cycle(1'b1, 1'b0, '0);
    chk("s6_restart_pc", bus.out_pc, 64'h0);

    // Randomized traffic: variable latency, stray responses, redirects, resets
    mem_lat  = 0;
    stray_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        rdy   = ($urandom_range(0, 3) < ((i / 300) % 4));
        redir = ($urandom_range(0, 11) == 0);
        rpc   = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                            : ({$urandom, $urandom} & ~64'h3);
        cycle(rdy, redir, rpc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
- REQ-001: Parameter WIDTH, default 64, SHALL set the PC and address width in bits.
- REQ-002: Parameter DEPTH, default 4, SHALL set the fetch-queue entry count; power of two, >= 2.
- REQ-003: Parameter RESET_PC, default 0, SHALL set the first fetch address after reset.
- REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-005: reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
- REQ-006: imem_req  output  1  SHALL request an instruction-memory read in this cycle.
- REQ-007: imem_addr  output  WIDTH  SHALL carry the read address; valid when imem_req=1.
- REQ-008: imem_rvalid  input  1  SHALL mark a returned instruction; in order, latency >= 1 cycle.
- REQ-009: imem_rdata  input  32  SHALL carry the returned instruction word.
- REQ-010: redirect_valid  input  1  SHALL request a pipeline flush and PC redirect (branch taken).
- REQ-011: redirect_pc  input  WIDTH  SHALL carry the redirect target.
- REQ-012: out_valid  output  1  SHALL be high when the queue head holds an instruction.
- REQ-013: out_ready  input  1  SHALL be high when the consumer (decode) accepts the head.
- REQ-014: out_instr  output  32  SHALL present the head instruction word.
- REQ-015: out_pc  output  WIDTH  SHALL present the head instruction's fetch address.
- REQ-016: count  output  $clog2(DEPTH+1)  SHALL report queue occupancy.

Function
- REQ-017: fetch_pc register SHALL hold the next fetch address; imem_addr SHALL equal fetch_pc.
- REQ-018: At most one memory request SHALL be outstanding; flag outstanding set on issue, cleared on imem_rvalid.
- REQ-019: imem_req SHALL be 1 iff reset deasserted, redirect_valid=0, (outstanding=0 or imem_rvalid=1), and count+outstanding < DEPTH using registered values.
- REQ-020: On issue, fetch_pc SHALL advance by 4 modulo 2^WIDTH; the issued address SHALL be saved as the pending PC.
- REQ-021: On imem_rvalid with outstanding=1 and discard=0, {imem_rdata, pending PC} SHALL be written at the tail.
- REQ-022: Handshake: pop occurs iff out_valid & out_ready; push and pop in the same cycle SHALL leave count unchanged.
- REQ-023: out_valid SHALL equal (count != 0); out_instr/out_pc SHALL be driven combinationally from the head entry; head SHALL hold stable while out_ready=0.
- REQ-024: Head/tail pointers SHALL be log2(DEPTH) bits and wrap naturally.
- REQ-025: Redirect SHALL set fetch_pc to redirect_pc and clear count and pointers next edge; it overrides push, pop and issue in that cycle.
- REQ-026: If a request is outstanding at redirect and imem_rvalid=0, discard SHALL be set; the next response SHALL be dropped and SHALL clear discard and outstanding.
- REQ-027: imem_rvalid in the redirect cycle SHALL be dropped and SHALL clear outstanding.
- REQ-028: imem_rvalid with outstanding=0 SHALL be ignored.
- REQ-029: Overflow is impossible by REQ-019; pushes never exceed DEPTH.

Reset
- REQ-030: reset=0 SHALL immediately force fetch_pc=RESET_PC, count=0, pointers=0, outstanding=0, discard=0, out_valid=0, and imem_req=0, independent of clk.
- REQ-031: Responses arriving after reset SHALL be ignored per REQ-028.
- REQ-032: Queue storage need not be reset.

Verification (WIDTH=64, DEPTH=4, RESET_PC=0, 1-cycle memory returning data = address)
- REQ-033: Release reset, out_ready=1 -> imem_addr 0,4,8,... every cycle; out_valid first high 2 edges after release; out_pc/out_instr 0,4,8 in order.
- REQ-034: out_ready=0 -> issues 0x0,0x4,0x8,0xC then imem_req=0, count=4; raise out_ready -> pops 0x0..0xC in order, fetch resumes at 0x10.
- REQ-035: Redirect to 0x100 while 0x8 is outstanding (rvalid next cycle) -> 0x8 dropped, count=0; next out_pc=0x100, then 0x104.
- REQ-036: redirect_valid, imem_rvalid and pop in the same cycle -> count=0 next edge, no push, imem_req=0 that cycle, fetch from redirect_pc the following cycle.
- REQ-037: Redirect to 0xFFFF_FFFF_FFFF_FFFC -> out_pc 0xFFFF_FFFF_FFFF_FFFC then 0x0.
- REQ-038: Drop reset mid-stream between edges -> out_valid=0, count=0, imem_req=0 immediately; a late rvalid is ignored; after release, fetch restarts at 0x0.
